// File: rtl/systolic_mac_core_if.sv
// Operand, handshake and result bundle for the 2x2 systolic multiplier.
// The master side issues start/operands; the slave side is the core.
interface systolic_mac_core_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
);
  logic              start;
  logic [DATA_W-1:0] a11, a12, a21, a22;
  logic [DATA_W-1:0] b11, b12, b21, b22;
  logic              busy;
  logic              done;
  logic              c_valid;
  logic [ACC_W-1:0]  c11, c12, c21, c22;

  modport master (
    output start, a11, a12, a21, a22, b11, b12, b21, b22,
    input  busy, done, c_valid, c11, c12, c21, c22
  );

  modport slave (
    input  start, a11, a12, a21, a22, b11, b12, b21, b22,
    output busy, done, c_valid, c11, c12, c21, c22
  );
endinterface

// File: rtl/systolic_mac_core.sv
// 2x2 output-stationary systolic array computing C = A x B over four RUN steps.
// A rows stream left-to-right and B columns top-to-bottom, skewed by row/column index.
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q, acc_d;

  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;

  assign acc_o = acc_q;
endmodule

module systolic_mac_core #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
) (
  input logic clk,
  input logic rst_n,
  systolic_mac_core_if.slave m
);
  localparam int N = 2;
  localparam int S = 4;  // feeder depth covers steps 0..3

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e state_q, state_d;
  logic [1:0] step_q;
  logic       c_valid_q;
  logic       accept, run;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_op, b_op;
  // a_sr_q[i] feeds row i, b_sr_q[j] feeds column j; slot 0 is the head
  logic [N-1:0][S-1:0][DATA_W-1:0] a_ld, b_ld, a_sr_q, b_sr_q;
  logic [N-1:0][DATA_W-1:0]        a_hop_q, b_hop_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc;

  assign a_op = {m.a22, m.a21, m.a12, m.a11};
  assign b_op = {m.b22, m.b21, m.b12, m.b11};

  assign accept = (state_q == IDLE) && m.start;
  assign run    = (state_q == RUN);

  // Row i holds a(i,k) in slot i+k; column j holds b(k,j) in slot j+k.
  for (genvar i = 0; i < N; i++) begin : g_ld
    for (genvar s = 0; s < S; s++) begin : g_s
      if (s >= i && s <= i+1) begin : g_op
        assign a_ld[i][s] = a_op[i][s-i];
        assign b_ld[i][s] = b_op[s-i][i];
      end else begin : g_zero
        assign a_ld[i][s] = '0;
        assign b_ld[i][s] = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m.start) state_d = RUN;
      RUN:     if (step_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      step_q    <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      a_hop_q   <= '0;
      b_hop_q   <= '0;
      c_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        step_q    <= '0;
        a_sr_q    <= a_ld;
        b_sr_q    <= b_ld;
        a_hop_q   <= '0;
        b_hop_q   <= '0;
        c_valid_q <= 1'b0;
      end else if (run) begin
        step_q <= step_q + 2'd1;
        for (int i = 0; i < N; i++) begin
          a_sr_q[i]  <= {{DATA_W{1'b0}}, a_sr_q[i][S-1:1]};
          b_sr_q[i]  <= {{DATA_W{1'b0}}, b_sr_q[i][S-1:1]};
          a_hop_q[i] <= a_sr_q[i][0];
          b_hop_q[i] <= b_sr_q[i][0];
        end
        if (step_q == 2'd3) c_valid_q <= 1'b1;
      end
    end
  end

  // PE(i,j) sees a(i,t-i-j) and b(t-i-j,j) at step t; it accumulates only for k in {0,1}.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int D = i + j;
      logic [DATA_W-1:0] a_in, b_in;
      logic              en;
      assign a_in = (j == 0) ? a_sr_q[i][0] : a_hop_q[i];
      assign b_in = (i == 0) ? b_sr_q[j][0] : b_hop_q[j];
      assign en   = run && (step_q >= 2'(D)) && (step_q <= 2'(D+1));
      systolic_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (en),
        .a_i   (a_in),
        .b_i   (b_in),
        .acc_o (acc[i][j])
      );
    end
  end

  // Partial sums stay hidden until the run has completed.
  assign m.busy    = run;
  assign m.done    = (state_q == DONE);
  assign m.c_valid = c_valid_q;
  assign m.c11     = c_valid_q ? acc[0][0] : '0;
  assign m.c12     = c_valid_q ? acc[0][1] : '0;
  assign m.c21     = c_valid_q ? acc[1][0] : '0;
  assign m.c22     = c_valid_q ? acc[1][1] : '0;
endmodule

// File: tb/tb_systolic_mac_core.sv
// Scoreboard bench: stimulus pushes hand-computed C per accepted start,
// a negedge monitor pops and compares on every done pulse.
module tb_systolic_mac_core;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 17;

  typedef logic [3:0][ACC_W-1:0] cvec_t;  // {c11,c12,c21,c22}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cyc[$];
  cvec_t exp_q[$];

  systolic_mac_core_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) m ();

  systolic_mac_core #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (m.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard compare on done, plus per-cycle protocol checks while busy.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (m.busy) begin
        busy_cnt++;
        chk("busy_and_done", {31'd0, m.done}, 32'd0);
        chk("hidden_while_busy", {m.c_valid, m.c11, m.c12, m.c21, m.c22} == '0, 32'd1);
      end
      if (m.done) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cvec_t e;
          cvec_t g;
          e = exp_q.pop_front();
          g = {m.c11, m.c12, m.c21, m.c22};
          chk("c11", g[3], e[3]);
          chk("c12", g[2], e[2]);
          chk("c21", g[1], e[1]);
          chk("c22", g[0], e[0]);
          chk("c_valid_on_done", {31'd0, m.c_valid}, 32'd1);
          chk("busy_cycles", busy_cnt, 4);
        end
        busy_cnt = 0;
      end
    end
  end

  // av/bv packed as {x11,x12,x21,x22}
  task automatic set_ops(input logic [3:0][7:0] av, input logic [3:0][7:0] bv);
    m.a11 = av[3]; m.a12 = av[2]; m.a21 = av[1]; m.a22 = av[0];
    m.b11 = bv[3]; m.b12 = bv[2]; m.b21 = bv[1]; m.b22 = bv[0];
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, m.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, m.done}, 32'd0);
    chk({tag, "_cvalid"}, {31'd0, m.c_valid}, 32'd0);
    chk({tag, "_c"}, {m.c11, m.c12, m.c21, m.c22} == '0, 32'd1);
  endtask

  // Caller guarantees IDLE; start is seen at the next edge (E0).
  task automatic run_mm(input logic [3:0][7:0] av, input logic [3:0][7:0] bv,
                        input cvec_t ev, input bit scramble);
    set_ops(av, bv);
    m.start = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk); #1;
    m.start = 1'b0;
    if (scramble) set_ops($urandom, $urandom);
    wait_drain(20);
  endtask

  initial begin
    m.start = 1'b0;
    set_ops('0, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic product, then results must hold in IDLE.
    run_mm({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8},
           {17'd19, 17'd22, 17'd43, 17'd50}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_cvalid", {31'd0, m.c_valid}, 32'd1);
    chk("hold_c11", m.c11, 32'd19);
    chk("hold_c22", m.c22, 32'd50);
    chk("hold_done", {31'd0, m.done}, 32'd0);

    // Max operands: 2*255*255 = 130050.
    run_mm({4{8'd255}}, {4{8'd255}}, {4{17'd130050}}, 1'b0);

    // Identity A, operands scrambled right after acceptance.
    run_mm({8'd1, 8'd0, 8'd0, 8'd1}, {8'd9, 8'd8, 8'd7, 8'd6},
           {17'd9, 17'd8, 17'd7, 17'd6}, 1'b1);
    @(posedge clk); #1;

    // Held start: edges E0..E17 see it, so accepts land on E0, E6, E12 only.
    set_ops({8'd2, 8'd0, 8'd1, 8'd3}, {8'd4, 8'd5, 8'd6, 8'd7});
    repeat (3) exp_q.push_back({17'd8, 17'd10, 17'd22, 17'd26});
    done_cyc.delete();
    m.start = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    m.start = 1'b0;
    wait_drain(20);
    repeat (8) @(posedge clk);
    #1;
    chk("held_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("held_period_1", done_cyc[1] - done_cyc[0], 6);
      chk("held_period_2", done_cyc[2] - done_cyc[1], 6);
    end

    // Reset at step 2 aborts the run; no done may follow.
    set_ops({8'd9, 8'd9, 8'd9, 8'd9}, {8'd9, 8'd9, 8'd9, 8'd9});
    m.start = 1'b1;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("rst_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mm({4{8'd1}}, {4{8'd1}}, {4{17'd2}}, 1'b0);

    // Starts during RUN (E2) and DONE (E5) are ignored: exactly one done.
    set_ops({8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd0, 8'd0, 8'd1});
    exp_q.push_back({17'd1, 17'd2, 17'd3, 17'd4});
    done_cyc.delete();
    m.start = 1'b1;
    @(posedge clk); #1;   // E0
    m.start = 1'b0;
    @(posedge clk); #1;   // E1
    m.start = 1'b1;
    @(posedge clk); #1;   // E2
    m.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;                   // E4, now DONE
    m.start = 1'b1;
    @(posedge clk); #1;   // E5
    m.start = 1'b0;
    wait_drain(20);
    repeat (10) @(posedge clk);
    #1;
    chk("ignored_start_done_count", done_cyc.size(), 1);
    chk("final_idle_busy", {31'd0, m.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
